wifi_tx_frame_sequencer: RTL and testbench

Sequences one WiFi TX PPDU preamble plus payload: short preamble generator, then long preamble generator, then data path (SIGNAL + DATA symbols from the IFFT/CP stage). Issues a one-cycle start pulse to each source, forwards the active source's I/Q stream onto a single registered output toward the DAC interface, checks segment lengths and guards against stalls. Sits between the TX control registers (AHB side) and the TX front-end mux.

---
 rtl/wifi_tx_frame_sequencer_if.sv | 50 +++++
 rtl/wifi_tx_frame_sequencer.sv | 155 +++++++++++++++
 tb/tb_wifi_tx_frame_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wifi_tx_frame_sequencer_if.sv
// rtl/wifi_tx_frame_sequencer_if.sv - control, source streams and DAC-side output of the TX frame sequencer
interface wifi_tx_frame_sequencer_if;
  logic        start;
  logic        abort;

  logic        short_start;
  logic        short_valid;
  logic [11:0] short_re;
  logic [11:0] short_im;
  logic        short_done;

  logic        long_start;
  logic        long_valid;
  logic [11:0] long_re;
  logic [11:0] long_im;
  logic        long_done;

  logic        data_start;
  logic        data_valid;
  logic [11:0] data_re;
  logic [11:0] data_im;
  logic        data_done;

  logic        out_valid;
  logic [11:0] out_re;
  logic [11:0] out_im;
  logic        busy;
  logic        frame_done;
  logic        len_err;
  logic        timeout_err;

  // master: TX control plus the three sample sources; slave: the sequencer
  modport master (
    output start, abort,
    output short_valid, short_re, short_im, short_done,
    output long_valid, long_re, long_im, long_done,
    output data_valid, data_re, data_im, data_done,
    input  short_start, long_start, data_start,
    input  out_valid, out_re, out_im, busy, frame_done, len_err, timeout_err
  );

  modport slave (
    input  start, abort,
    input  short_valid, short_re, short_im, short_done,
    input  long_valid, long_re, long_im, long_done,
    input  data_valid, data_re, data_im, data_done,
    output short_start, long_start, data_start,
    output out_valid, out_re, out_im, busy, frame_done, len_err, timeout_err
  );
endinterface

// File: rtl/wifi_tx_frame_sequencer.sv
// rtl/wifi_tx_frame_sequencer.sv - sequences short preamble, long preamble and data of one TX PPDU
module wifi_tx_frame_sequencer #(
  parameter int SHORT_LEN  = 160,
  parameter int LONG_LEN   = 161,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 255
) (
  input logic                      clk,
  input logic                      reset,
  wifi_tx_frame_sequencer_if.slave tx
);
  localparam int GW = $clog2(GAP_CYCLES + 2);

  typedef enum logic [2:0] {IDLE, SHORT, LONG, DATA, GAP} state_t;

  state_t        state;
  logic [8:0]    seg_cnt;
  logic [7:0]    stall_cnt;
  logic [GW-1:0] gap_cnt;

  logic          sel_valid;
  logic          sel_done;
  logic [11:0]   sel_re;
  logic [11:0]   sel_im;
  logic [8:0]    cnt_next;

  always_comb begin
    sel_valid = 1'b0;
    sel_done  = 1'b0;
    sel_re    = '0;
    sel_im    = '0;
    case (state)
      SHORT: begin
        sel_valid = tx.short_valid;
        sel_done  = tx.short_done;
        sel_re    = tx.short_re;
        sel_im    = tx.short_im;
      end
      LONG: begin
        sel_valid = tx.long_valid;
        sel_done  = tx.long_done;
        sel_re    = tx.long_re;
        sel_im    = tx.long_im;
      end
      DATA: begin
        sel_valid = tx.data_valid;
        sel_done  = tx.data_done;
        sel_re    = tx.data_re;
        sel_im    = tx.data_im;
      end
      default: ;
    endcase
  end

  // length check includes the sample that arrives together with done
  assign cnt_next = seg_cnt + {8'd0, sel_valid};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      seg_cnt        <= '0;
      stall_cnt      <= '0;
      gap_cnt        <= '0;
      tx.short_start <= 1'b0;
      tx.long_start  <= 1'b0;
      tx.data_start  <= 1'b0;
      tx.out_valid   <= 1'b0;
      tx.out_re      <= '0;
      tx.out_im      <= '0;
      tx.busy        <= 1'b0;
      tx.frame_done  <= 1'b0;
      tx.len_err     <= 1'b0;
      tx.timeout_err <= 1'b0;
    end else begin
      tx.short_start <= 1'b0;
      tx.long_start  <= 1'b0;
      tx.data_start  <= 1'b0;
      tx.frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          tx.out_valid <= 1'b0;
          tx.out_re    <= '0;
          tx.out_im    <= '0;
          if (tx.start && !tx.abort) begin
            state          <= SHORT;
            tx.busy        <= 1'b1;
            tx.short_start <= 1'b1;
            seg_cnt        <= '0;
            stall_cnt      <= '0;
            tx.len_err     <= 1'b0;
            tx.timeout_err <= 1'b0;
          end
        end
        SHORT, LONG, DATA: begin
          if (tx.abort) begin
            state        <= IDLE;
            tx.busy      <= 1'b0;
            tx.out_valid <= 1'b0;
            tx.out_re    <= '0;
            tx.out_im    <= '0;
          end else begin
            tx.out_valid <= sel_valid;
            tx.out_re    <= sel_valid ? sel_re : '0;
            tx.out_im    <= sel_valid ? sel_im : '0;
            if (sel_done) begin
              seg_cnt   <= '0;
              stall_cnt <= '0;
              if (state == SHORT) begin
                if (cnt_next != 9'(SHORT_LEN)) tx.len_err <= 1'b1;
                state         <= LONG;
                tx.long_start <= 1'b1;
              end else if (state == LONG) begin
                if (cnt_next != 9'(LONG_LEN)) tx.len_err <= 1'b1;
                state         <= DATA;
                tx.data_start <= 1'b1;
              end else begin
                state         <= GAP;
                gap_cnt       <= '0;
                tx.frame_done <= 1'b1;
              end
            end else begin
              seg_cnt <= cnt_next;
              if (sel_valid) begin
                stall_cnt <= '0;
              end else if (stall_cnt == 8'(TIMEOUT - 1)) begin
                stall_cnt      <= '0;
                tx.timeout_err <= 1'b1;
                state          <= GAP;
                gap_cnt        <= '0;
              end else begin
                stall_cnt <= stall_cnt + 8'd1;
              end
            end
          end
        end
        GAP: begin
          tx.out_valid <= 1'b0;
          tx.out_re    <= '0;
          tx.out_im    <= '0;
          // GAP lasts GAP_CYCLES+1 cycles so a zero gap still takes one pass
          if (tx.abort || gap_cnt == GW'(GAP_CYCLES)) begin
            state   <= IDLE;
            tx.busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          tx.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wifi_tx_frame_sequencer.sv
// tb/tb_wifi_tx_frame_sequencer.sv - directed bench with a scenario-level expectation model for the TX frame sequencer
module tb_wifi_tx_frame_sequencer;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wifi_tx_frame_sequencer_if tx();

  wifi_tx_frame_sequencer #(
    .SHORT_LEN(160), .LONG_LEN(161), .GAP_CYCLES(GAP), .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx(tx)
  );

  typedef struct {
    int          due;
    logic [11:0] re;
    logic [11:0] im;
  } samp_t;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  bit    chk_en = 1'b0;
  samp_t sq[$];
  bit    exp_ss[int];
  bit    exp_ls[int];
  bit    exp_ds[int];
  bit    exp_fd[int];
  bit    exp_busy[int];

  int    n_valid = 0, n_fd = 0, fd_cyc = 0, busy_fall = 0, te_rise = 0;
  logic  busy_d = 1'b0, te_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // expected output stream: each forwarded sample shows up exactly on its due cycle, nothing else is valid
  always @(negedge clk) begin
    if (chk_en) begin
      if (sq.size() > 0 && sq[0].due == cyc) begin
        check("out_valid", int'(tx.out_valid), 1);
        check("out_re", int'(tx.out_re), int'(sq[0].re));
        check("out_im", int'(tx.out_im), int'(sq[0].im));
        void'(sq.pop_front());
      end else begin
        check("out_valid_idle", int'(tx.out_valid), 0);
        check("out_re_idle", int'(tx.out_re), 0);
        check("out_im_idle", int'(tx.out_im), 0);
      end
      check("short_start", int'(tx.short_start), int'(exp_ss.exists(cyc)));
      check("long_start", int'(tx.long_start), int'(exp_ls.exists(cyc)));
      check("data_start", int'(tx.data_start), int'(exp_ds.exists(cyc)));
      check("frame_done", int'(tx.frame_done), int'(exp_fd.exists(cyc)));
      check("busy", int'(tx.busy), int'(exp_busy.exists(cyc)));
    end
  end

  always @(negedge clk) begin
    if (tx.out_valid) n_valid++;
    if (tx.frame_done) begin n_fd++; fd_cyc = cyc; end
    if (busy_d && !tx.busy) busy_fall = cyc;
    if (tx.timeout_err && !te_d) te_rise = cyc;
    busy_d = tx.busy;
    te_d   = tx.timeout_err;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sel 0/1/2 picks the real source; the other sources carry junk samples and stray done flags
  task automatic drive(input int sel, input bit v, input logic [11:0] re, input logic [11:0] im, input bit done);
    logic [11:0] j;
    j = 12'($urandom);
    tx.short_valid = 1'b1; tx.short_re = j;  tx.short_im = ~j; tx.short_done = ($urandom_range(0, 3) == 0);
    tx.long_valid  = 1'b1; tx.long_re  = ~j; tx.long_im  = j;  tx.long_done  = ($urandom_range(0, 3) == 0);
    tx.data_valid  = 1'b1; tx.data_re  = j;  tx.data_im  = j;  tx.data_done  = ($urandom_range(0, 3) == 0);
    case (sel)
      0: begin tx.short_valid = v; tx.short_re = re; tx.short_im = im; tx.short_done = done; end
      1: begin tx.long_valid  = v; tx.long_re  = re; tx.long_im  = im; tx.long_done  = done; end
      2: begin tx.data_valid  = v; tx.data_re  = re; tx.data_im  = im; tx.data_done  = done; end
      default: ;
    endcase
  endtask

  task automatic begin_frame(input bit hold);
    tx.start = 1'b1;
    drive(3, 1'b0, 12'd0, 12'd0, 1'b0);
    step();
    if (!hold) tx.start = 1'b0;
    exp_ss[cyc] = 1'b1;
  endtask

  // mode 0: done on last sample, 1: done on an extra empty cycle, 2: no done
  task automatic send_seg(input int sel, input int n, input int mode);
    samp_t s;
    for (int i = 0; i < n; i++) begin
      s.due = cyc + 1;
      s.re  = 12'($urandom);
      s.im  = 12'($urandom);
      drive(sel, 1'b1, s.re, s.im, (mode == 0) && (i == n - 1));
      exp_busy[cyc] = 1'b1;
      sq.push_back(s);
      step();
    end
    if (mode == 1) begin
      drive(sel, 1'b0, 12'd0, 12'd0, 1'b1);
      exp_busy[cyc] = 1'b1;
      step();
    end
    if (mode != 2) begin
      case (sel)
        0: exp_ls[cyc] = 1'b1;
        1: exp_ds[cyc] = 1'b1;
        default: exp_fd[cyc] = 1'b1;
      endcase
    end
  endtask

  task automatic gap_and_idle(input bit hold);
    tx.start = hold;
    for (int i = 0; i <= GAP; i++) begin
      drive(3, 1'b0, 12'd0, 12'd0, 1'b0);
      exp_busy[cyc] = 1'b1;
      step();
    end
    drive(3, 1'b0, 12'd0, 12'd0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_out_valid"}, int'(tx.out_valid), 0);
    check({tag, "_out_re"}, int'(tx.out_re), 0);
    check({tag, "_out_im"}, int'(tx.out_im), 0);
    check({tag, "_starts"}, int'({tx.short_start, tx.long_start, tx.data_start}), 0);
    check({tag, "_busy"}, int'(tx.busy), 0);
    check({tag, "_frame_done"}, int'(tx.frame_done), 0);
    check({tag, "_errs"}, int'({tx.len_err, tx.timeout_err}), 0);
  endtask

  initial begin
    int v;
    samp_t s;
    reset = 1'b1;
    tx.start = 1'b0;
    tx.abort = 1'b0;
    drive(3, 1'b0, 12'd0, 12'd0, 1'b0);
    step(); step(); step();
    chk_all_zero("reset");
    reset = 1'b0;
    chk_en = 1'b1;
    step();

    // nominal frame
    n_valid = 0; n_fd = 0;
    begin_frame(1'b0);
    send_seg(0, 160, 0);
    send_seg(1, 161, 0);
    send_seg(2, 80, 0);
    gap_and_idle(1'b0);
    step();
    check("nom_valid_count", n_valid, 401);
    check("nom_frame_done_count", n_fd, 1);
    check("nom_busy_fall_delay", busy_fall - fd_cyc, 5);
    check("nom_len_err", int'(tx.len_err), 0);

    // long preamble short by 11 samples
    n_fd = 0;
    begin_frame(1'b0);
    send_seg(0, 160, 0);
    send_seg(1, 150, 0);
    check("len_err_set", int'(tx.len_err), 1);
    send_seg(2, 80, 0);
    gap_and_idle(1'b0);
    check("len_frame_done_count", n_fd, 1);
    check("len_err_sticky", int'(tx.len_err), 1);

    // accepted start clears len_err; done arriving without a sample is not counted
    begin_frame(1'b0);
    check("len_err_cleared", int'(tx.len_err), 0);
    send_seg(0, 160, 0);
    send_seg(1, 161, 1);
    send_seg(2, 40, 0);
    gap_and_idle(1'b0);
    check("late_done_len_err", int'(tx.len_err), 0);

    // data source stalls after 20 samples
    n_fd = 0;
    begin_frame(1'b0);
    send_seg(0, 160, 0);
    send_seg(1, 161, 0);
    send_seg(2, 20, 2);
    v = cyc - 1;
    for (int k = 1; k <= 255; k++) begin
      if (k == 255) check("timeout_not_yet", int'(tx.timeout_err), 0);
      drive(2, 1'b0, 12'd0, 12'd0, 1'b0);
      exp_busy[cyc] = 1'b1;
      step();
    end
    gap_and_idle(1'b0);
    step();
    check("timeout_latency", te_rise - v, 256);
    check("timeout_err_sticky", int'(tx.timeout_err), 1);
    check("timeout_no_frame_done", n_fd, 0);

    // abort on long sample 50, then restart immediately
    begin_frame(1'b0);
    check("timeout_err_cleared", int'(tx.timeout_err), 0);
    send_seg(0, 160, 0);
    send_seg(1, 49, 2);
    s.re = 12'($urandom);
    s.im = 12'($urandom);
    drive(1, 1'b1, s.re, s.im, 1'b0);
    tx.abort = 1'b1;
    exp_busy[cyc] = 1'b1;
    step();
    tx.abort = 1'b0;
    check("abort_busy", int'(tx.busy), 0);
    begin_frame(1'b0);
    send_seg(0, 160, 0);
    send_seg(1, 161, 0);
    send_seg(2, 30, 0);
    gap_and_idle(1'b0);

    // start held through a whole frame and its gap
    n_fd = 0;
    begin_frame(1'b1);
    send_seg(0, 160, 0);
    send_seg(1, 161, 0);
    send_seg(2, 24, 0);
    gap_and_idle(1'b1);
    begin_frame(1'b0);
    check("hold_frame_done_count", n_fd, 1);
    send_seg(0, 160, 0);
    send_seg(1, 161, 0);
    send_seg(2, 16, 0);
    gap_and_idle(1'b0);

    // start and abort together in IDLE: abort wins
    tx.start = 1'b1;
    tx.abort = 1'b1;
    step();
    tx.start = 1'b0;
    tx.abort = 1'b0;
    check("start_abort_idle_busy", int'(tx.busy), 0);
    step();

    // asynchronous reset in the middle of DATA
    begin_frame(1'b0);
    send_seg(0, 160, 0);
    send_seg(1, 161, 0);
    send_seg(2, 10, 2);
    #2;
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    sq.delete();
    drive(3, 1'b0, 12'd0, 12'd0, 1'b0);
    step(); step();
    reset = 1'b0;
    chk_en = 1'b1;
    step();
    n_fd = 0;
    begin_frame(1'b0);
    send_seg(0, 160, 0);
    send_seg(1, 161, 0);
    send_seg(2, 12, 0);
    gap_and_idle(1'b0);
    step();
    check("post_reset_frame_done_count", n_fd, 1);
    check("sample_queue_drained", sq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
